// File: rtl/rtlola_event_feeder.sv
// Timestamped event feeder for the RTLola monitor input interface.
// Buffers host events in a FIFO and replays each one as a registered strobe once its due time is reached.
module rtlola_event_feeder #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [TS_W-1:0]   s_ts,
    input  logic [DATA_W-1:0] s_data0,
    input  logic              s_new0,
    input  logic [DATA_W-1:0] s_data1,
    input  logic              s_new1,
    output logic [DATA_W-1:0] input_0,
    output logic              new_input_0,
    output logic [DATA_W-1:0] input_1,
    output logic              new_input_1,
    output logic [TS_W-1:0]   time_now,
    output logic              busy,
    output logic              late_err,
    output logic              order_err
);

    // state    | meaning
    // ST_EMPTY | FIFO empty, nothing to replay
    // ST_WAIT  | head entry present, waiting for its due time (or en)

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_W + 2 * DATA_W + 2;

    typedef enum logic {ST_EMPTY, ST_WAIT} state_t;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    state_t            r_state;
    logic [TS_W-1:0]   r_time;
    logic [TS_W-1:0]   r_last_ts;
    logic [DATA_W-1:0] r_input_0;
    logic [DATA_W-1:0] r_input_1;
    logic              r_new_0;
    logic              r_new_1;
    logic              r_late_err;
    logic              r_order_err;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_due;
    logic [EW-1:0]     w_head;
    logic [TS_W-1:0]   w_head_ts;
    logic [DATA_W-1:0] w_head_d0;
    logic [DATA_W-1:0] w_head_d1;
    logic              w_head_n0;
    logic              w_head_n1;
    logic [TS_W-1:0]   w_age;
    logic [CW-1:0]     w_count_nxt;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = s_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_ts = w_head[EW-1 -: TS_W];
    assign w_head_d0 = w_head[2*DATA_W+1 -: DATA_W];
    assign w_head_n0 = w_head[DATA_W+1];
    assign w_head_d1 = w_head[DATA_W -: DATA_W];
    assign w_head_n1 = w_head[0];

    // Modular age: due when the head timestamp lies in the past half of the counter range.
    assign w_age       = r_time - w_head_ts;
    assign w_due       = !w_age[TS_W-1];
    assign w_pop       = en && (r_state == ST_WAIT) && w_due;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_ts, s_data0, s_new0, s_data1, s_new1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= ST_EMPTY;
            r_time      <= '0;
            r_last_ts   <= '0;
            r_input_0   <= '0;
            r_input_1   <= '0;
            r_new_0     <= 1'b0;
            r_new_1     <= 1'b0;
            r_late_err  <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            if (en) begin
                r_time <= r_time + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_last_ts <= s_ts;
                if (s_ts < r_last_ts) begin
                    r_order_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_time != w_head_ts) begin
                    r_late_err <= 1'b1;
                end
            end
            r_new_0   <= w_pop && w_head_n0;
            r_new_1   <= w_pop && w_head_n1;
            r_input_0 <= (w_pop && w_head_n0) ? w_head_d0 : '0;
            r_input_1 <= (w_pop && w_head_n1) ? w_head_d1 : '0;
            r_count   <= w_count_nxt;
            case (r_state)
                ST_EMPTY: if (w_push) r_state <= ST_WAIT;
                ST_WAIT:  if (w_count_nxt == '0) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    assign s_ready     = !w_full;
    assign busy        = (r_count != '0);
    assign time_now    = r_time;
    assign input_0     = r_input_0;
    assign input_1     = r_input_1;
    assign new_input_0 = r_new_0;
    assign new_input_1 = r_new_1;
    assign late_err    = r_late_err;
    assign order_err   = r_order_err;

endmodule

// File: tb/tb_rtlola_event_feeder.sv
// Scoreboard bench for rtlola_event_feeder: the driver predicts each event's strobe time and payload,
// a negedge monitor pops predictions whenever the DUT strobes.
module tb_rtlola_event_feeder;

    localparam int DATA_W = 64;
    localparam int TS_W   = 32;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic              s_valid;
    logic              s_ready;
    logic [TS_W-1:0]   s_ts;
    logic [DATA_W-1:0] s_data0;
    logic              s_new0;
    logic [DATA_W-1:0] s_data1;
    logic              s_new1;
    logic [DATA_W-1:0] input_0;
    logic              new_input_0;
    logic [DATA_W-1:0] input_1;
    logic              new_input_1;
    logic [TS_W-1:0]   time_now;
    logic              busy;
    logic              late_err;
    logic              order_err;

    rtlola_event_feeder #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_valid(s_valid), .s_ready(s_ready), .s_ts(s_ts),
        .s_data0(s_data0), .s_new0(s_new0), .s_data1(s_data1), .s_new1(s_new1),
        .input_0(input_0), .new_input_0(new_input_0),
        .input_1(input_1), .new_input_1(new_input_1),
        .time_now(time_now), .busy(busy), .late_err(late_err), .order_err(order_err)
    );

    typedef struct {
        logic [TS_W-1:0]   tn;
        logic [DATA_W-1:0] d0;
        logic              n0;
        logic [DATA_W-1:0] d1;
        logic              n1;
    } exp_t;

    exp_t            exp_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [TS_W-1:0] tb_tn    = '0;
    longint          m_last_pop;
    logic [TS_W-1:0] m_last_ts;
    logic            m_late;
    logic            m_order;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle counter.
    always @(posedge clk) begin
        if (rst) tb_tn <= '0;
        else if (en) tb_tn <= tb_tn + 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        n_checks++;
        if (time_now !== tb_tn) begin
            n_fail++;
            $display("FAIL time_now: got %0d expected %0d", time_now, tb_tn);
        end
        if (new_input_0 === 1'b1 || new_input_1 === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stray_strobe: strobe %b%b at time_now=%0d, expected none",
                         new_input_0, new_input_1, time_now);
            end else begin
                e = exp_q.pop_front();
                if (time_now !== e.tn || new_input_0 !== e.n0 || new_input_1 !== e.n1 ||
                    input_0 !== (e.n0 ? e.d0 : '0) || input_1 !== (e.n1 ? e.d1 : '0)) begin
                    n_fail++;
                    $display("FAIL strobe: got t=%0d n=%b%b d0=%0h d1=%0h expected t=%0d n=%b%b d0=%0h d1=%0h",
                             time_now, new_input_0, new_input_1, input_0, input_1,
                             e.tn, e.n0, e.n1, e.n0 ? e.d0 : '0, e.n1 ? e.d1 : '0);
                end
            end
        end
        n_checks++;
        if ((new_input_0 !== 1'b1 && input_0 !== '0) || (new_input_1 !== 1'b1 && input_1 !== '0)) begin
            n_fail++;
            $display("FAIL idle_data: got input_0=%0h input_1=%0h expected 0 without strobe", input_0, input_1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        exp_q.delete();
        m_last_pop = -1;
        m_last_ts  = '0;
        m_late     = 1'b0;
        m_order    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || time_now !== '0 || s_ready !== 1'b1 || late_err !== 1'b0 ||
            order_err !== 1'b0 || new_input_0 !== 1'b0 || new_input_1 !== 1'b0 ||
            input_0 !== '0 || input_1 !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b tn=%0d rdy=%b late=%b ord=%b new=%b%b expected 0 0 1 0 0 00",
                     busy, time_now, s_ready, late_err, order_err, new_input_0, new_input_1);
        end
        rst = 1'b0;
    endtask

    // Strobe time from the replay rules: pop in the cycle where time_now = max(ts, push+1, prev pop+1).
    task automatic push_ev(input logic [TS_W-1:0] ts, input logic [DATA_W-1:0] d0, input logic n0,
                           input logic [DATA_W-1:0] d1, input logic n1);
        int     w;
        longint p;
        exp_t   e;
        @(negedge clk);
        s_valid = 1'b1;
        s_ts = ts;
        s_data0 = d0;
        s_new0 = n0;
        s_data1 = d1;
        s_new1 = n1;
        w = 0;
        while (s_ready !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (s_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: s_ready=%b expected 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        p = longint'(ts);
        if (longint'(tb_tn) + 1 > p) p = longint'(tb_tn) + 1;
        if (m_last_pop + 1 > p) p = m_last_pop + 1;
        m_last_pop = p;
        if (p != longint'(ts)) m_late = 1'b1;
        if (ts < m_last_ts) m_order = 1'b1;
        m_last_ts = ts;
        if (n0 || n1) begin
            e.tn = TS_W'(p + 1);
            e.d0 = d0;
            e.n0 = n0;
            e.d1 = d1;
            e.n1 = n1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_tn(input logic [TS_W-1:0] target);
        int g;
        g = 0;
        while (tb_tn < target && g < 10000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic drain(input int budget);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && g < budget) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got busy=%b pending=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic check_flags(input string name);
        n_checks++;
        if (late_err !== m_late || order_err !== m_order) begin
            n_fail++;
            $display("FAIL flags_%s: got late=%b order=%b expected late=%b order=%b",
                     name, late_err, order_err, m_late, m_order);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        s_valid = 1'b0;
        s_ts = '0;
        s_data0 = '0;
        s_new0 = 1'b0;
        s_data1 = '0;
        s_new1 = 1'b0;
        m_last_pop = -1;
        m_last_ts = '0;
        m_late = 1'b0;
        m_order = 1'b0;

        // Single on-time event.
        do_reset();
        wait_tn(5);
        push_ev(1000, 64'd1, 1'b1, 64'd1, 1'b1);
        drain(2000);
        check_flags("single");

        // Four spaced events.
        do_reset();
        for (int i = 1; i <= 4; i++) push_ev(TS_W'(1000 * i), DATA_W'(i), 1'b1, DATA_W'(i), 1'b1);
        drain(6000);
        check_flags("four");

        // Fill past capacity with equal timestamps.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_ev(500, DATA_W'(i + 10), 1'b1, DATA_W'(i + 20), 1'b0);
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got s_ready=%b expected 0", s_ready);
        end
        push_ev(500, 64'd99, 1'b1, 64'd98, 1'b1);
        drain(2000);
        check_flags("full");

        // Late event, then out-of-order event.
        do_reset();
        wait_tn(50);
        push_ev(10, 64'hdead, 1'b1, 64'hbeef, 1'b1);
        push_ev(5, 64'h55, 1'b0, 64'h66, 1'b1);
        drain(200);
        check_flags("late_order");

        // Enable held low across the due time.
        do_reset();
        wait_tn(10);
        push_ev(100, 64'h100, 1'b1, 64'h200, 1'b0);
        wait_tn(95);
        @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        drain(200);
        check_flags("enable");

        // Reset with events still queued.
        do_reset();
        for (int i = 0; i < 3; i++) push_ev(TS_W'(60 + i), DATA_W'(i + 1), 1'b1, '0, 1'b0);
        do_reset();
        repeat (100) @(negedge clk);
        check_flags("reset_q");

        // Randomized traffic: near, past and future timestamps, random strobe masks and gaps.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 16; k++) begin
                int t;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                t = int'(tb_tn) + int'($urandom_range(0, 30)) - int'($urandom_range(0, 12));
                if (t < 0) t = 0;
                push_ev(TS_W'(t), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                        {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            end
            drain(1000);
            check_flags("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
